// File: rtl/d_toggle_gen_pkg.sv
// Shared types and constants for the d_toggle_gen flop stimulus driver.
//   state_e    : sequencer states
//   LFSR_TAPS  : Galois tap mask for the right-shifting 16-bit LFSR
//   CNT_W      : width of the toggle and delay counters
//   lfsr_step  : one LFSR advance
package d_toggle_gen_pkg;

  localparam int unsigned CNT_W     = 8;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StRun,
    StSet,
    StDone
  } state_e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/d_toggle_gen_lfsr16.sv
// 16-bit Galois LFSR, shift right, advancing one step whenever adv_i is high.
//   clk     : clock, rising edge
//   reset   : asynchronous active-high reset, loads SEED
//   adv_i   : advance one step on this edge
//   value_o : current LFSR contents
module lfsr16
  import d_toggle_gen_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adv_i,
  output logic [15:0] value_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (adv_i) lfsr_d = lfsr_step(lfsr_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/d_toggle_gen.sv
// Stimulus driver for one D flop under test: toggles d while the flop is held in reset,
// releases reset and toggles again, forces d=1, then re-asserts reset.
//   clk          : clock, rising edge
//   reset        : asynchronous active-high reset
//   start_i      : begin a run (sampled only in idle/done)
//   d_out_o      : drives flop d
//   rstn_out_o   : drives flop reset_n (active-low)
//   busy_o       : run in progress
//   done_o       : run finished; cleared by start or reset
//   toggle_cnt_o : toggles completed in the current phase
// Build option: define FIXED_DELAY_EN to make every interval MAX_DELAY and drop the LFSR.
module d_toggle_gen
  import d_toggle_gen_pkg::*;
#(
  parameter int unsigned NUM_TOGGLES = 5,
  parameter int unsigned MIN_DELAY   = 1,
  parameter int unsigned MAX_DELAY   = 3,
  parameter int unsigned SET_GAP     = 1,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  output logic             d_out_o,
  output logic             rstn_out_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] toggle_cnt_o
);

  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("d_toggle_gen: LFSR_SEED must be non-zero");
  end
  if (NUM_TOGGLES < 1 || NUM_TOGGLES > 255) begin : g_bad_num
    $error("d_toggle_gen: NUM_TOGGLES out of range");
  end
  if (MIN_DELAY < 1 || MAX_DELAY < MIN_DELAY || MAX_DELAY > 15) begin : g_bad_delay
    $error("d_toggle_gen: delay range invalid");
  end
  if (SET_GAP < 1 || SET_GAP > 255) begin : g_bad_gap
    $error("d_toggle_gen: SET_GAP out of range");
  end

  state_e           state_q;
  logic             d_out_q, rstn_q, busy_q, done_q;
  logic [CNT_W-1:0] toggle_cnt_q, cnt_q;
  logic [CNT_W-1:0] delay_new;
  logic             start_ok, tick, last;

  assign start_ok = start_i && (state_q == StIdle || state_q == StDone);
  assign tick     = (state_q == StPre || state_q == StRun) && (cnt_q == CNT_W'(1));
  assign last     = tick && (toggle_cnt_q == CNT_W'(NUM_TOGGLES - 1));

`ifdef FIXED_DELAY_EN
  assign delay_new = CNT_W'(MAX_DELAY);
`else
  localparam int unsigned DelaySpan = MAX_DELAY - MIN_DELAY + 1;

  logic [15:0] lfsr_val;
  logic [3:0]  delay_off;
  logic        load_delay;
  logic        unused_lfsr_hi;

  // Every delay load consumes exactly one LFSR step; the final RUN toggle loads SET_GAP instead.
  assign load_delay = start_ok || (tick && !(state_q == StRun && last));

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .adv_i   (load_delay),
    .value_o (lfsr_val)
  );

  assign delay_off      = 4'(32'(lfsr_val[3:0]) % DelaySpan);
  assign delay_new      = CNT_W'(MIN_DELAY) + CNT_W'(delay_off);
  assign unused_lfsr_hi = ^lfsr_val[15:4];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      d_out_q      <= 1'b0;
      rstn_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      toggle_cnt_q <= '0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            state_q      <= StPre;
            d_out_q      <= 1'b0;
            rstn_q       <= 1'b0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            toggle_cnt_q <= '0;
            cnt_q        <= delay_new;
          end
        end
        StPre: begin
          if (tick) begin
            d_out_q <= ~d_out_q;
            cnt_q   <= delay_new;
            if (last) begin
              rstn_q       <= 1'b1;
              state_q      <= StRun;
              toggle_cnt_q <= '0;
            end else begin
              toggle_cnt_q <= toggle_cnt_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StRun: begin
          if (tick) begin
            toggle_cnt_q <= toggle_cnt_q + 1'b1;
            if (last) begin
              d_out_q <= 1'b1;
              state_q <= StSet;
              cnt_q   <= CNT_W'(SET_GAP);
            end else begin
              d_out_q <= ~d_out_q;
              cnt_q   <= delay_new;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StSet: begin
          if (cnt_q <= CNT_W'(1)) begin
            rstn_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign d_out_o      = d_out_q;
  assign rstn_out_o   = rstn_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign toggle_cnt_o = toggle_cnt_q;

endmodule

// File: tb/tb_d_toggle_gen.sv
`timescale 1ns/1ps
module tb_d_toggle_gen;

  typedef struct packed {
    logic       d;
    logic       rstn;
    logic       busy;
    logic       done;
    logic [7:0] cnt;
  } exp_t;

  localparam logic [15:0] Seed = 16'hACE1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic st [3];

  logic       d0, rn0, bz0, dn0, d1, rn1, bz1, dn1, d2, rn2, bz2, dn2;
  logic [7:0] tc0, tc1, tc2;
  exp_t       obs [3];

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];
  int   tog_k[$];
  int   rise_k, fall_k;
  logic d_at_fall;

  always #5 clk = ~clk;

  // u_dut: random delays 1..3; u_fix: delay always 3; u_one: single toggle, delay 1
  d_toggle_gen u_dut (
    .clk(clk), .reset(reset), .start_i(st[0]), .d_out_o(d0), .rstn_out_o(rn0),
    .busy_o(bz0), .done_o(dn0), .toggle_cnt_o(tc0)
  );
  d_toggle_gen #(.MIN_DELAY(3), .MAX_DELAY(3)) u_fix (
    .clk(clk), .reset(reset), .start_i(st[1]), .d_out_o(d1), .rstn_out_o(rn1),
    .busy_o(bz1), .done_o(dn1), .toggle_cnt_o(tc1)
  );
  d_toggle_gen #(.NUM_TOGGLES(1), .MIN_DELAY(1), .MAX_DELAY(1)) u_one (
    .clk(clk), .reset(reset), .start_i(st[2]), .d_out_o(d2), .rstn_out_o(rn2),
    .busy_o(bz2), .done_o(dn2), .toggle_cnt_o(tc2)
  );

  assign obs[0] = {d0, rn0, bz0, dn0, tc0};
  assign obs[1] = {d1, rn1, bz1, dn1, tc1};
  assign obs[2] = {d2, rn2, bz2, dn2, tc2};

  function automatic logic [15:0] lfsr_model(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  // Expected per-cycle outputs from the start edge (k=0) until two cycles into DONE.
  task automatic build_expect(input int n, input int mn, input int mx, input int gap,
                              input logic [15:0] seed_in, output logic [15:0] seed_nxt,
                              output int pre_end);
    int         ev_t[$];
    exp_t       ev_s[$];
    exp_t       s;
    logic [15:0] x;
    int         t, dly, j;
    x = seed_in;
    t = 0;
    pre_end = 0;
    s = '{d: 1'b0, rstn: 1'b0, busy: 1'b1, done: 1'b0, cnt: 8'd0};
    ev_t.push_back(0);
    ev_s.push_back(s);
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 1; i <= n; i++) begin
        dly = mn + (int'({28'd0, x[3:0]}) % (mx - mn + 1));
        x = lfsr_model(x);
        t += dly;
        s.cnt = 8'(i);
        if (ph == 0) begin
          s.d = ~s.d;
          if (i == n) begin
            s.rstn  = 1'b1;
            s.cnt   = 8'd0;
            pre_end = t;
          end
        end else begin
          if (i == n) s.d = 1'b1;
          else        s.d = ~s.d;
        end
        ev_t.push_back(t);
        ev_s.push_back(s);
      end
    end
    t += gap;
    s.rstn = 1'b0;
    s.busy = 1'b0;
    s.done = 1'b1;
    ev_t.push_back(t);
    ev_s.push_back(s);
    j = 0;
    for (int k = 0; k <= t + 2; k++) begin
      while (j + 1 < ev_t.size() && ev_t[j+1] <= k) j++;
      exp_q.push_back(ev_s[j]);
    end
    seed_nxt = x;
  endtask

  // Caller raises st[sel] at a negedge; the next posedge is e0.
  task automatic run_compare(input int sel, input int pulse_at, input int stop_k);
    exp_t e, o;
    logic pd, prn;
    int   k;
    k = 0;
    pd = 1'b0;
    prn = 1'b0;
    tog_k.delete();
    rise_k = -1;
    fall_k = -1;
    d_at_fall = 1'b0;
    while (exp_q.size() > 0 && k <= stop_k) begin
      @(negedge clk);
      st[sel] = (pulse_at > 0 && k == pulse_at - 1);
      e = exp_q.pop_front();
      o = obs[sel];
      chk($sformatf("trace%0d_e%0d", sel, k), {20'd0, o}, {20'd0, e});
      if (k > 0 && o.d != pd) tog_k.push_back(k);
      if (!prn && o.rstn) rise_k = k;
      if (prn && !o.rstn) begin
        fall_k = k;
        d_at_fall = o.d;
      end
      pd = o.d;
      prn = o.rstn;
      k++;
    end
    st[sel] = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_props(input string tag, output int sig);
    int pre, bad, prev, g;
    pre = 0;
    bad = 0;
    prev = 0;
    sig = 0;
    foreach (tog_k[i]) begin
      if (tog_k[i] <= rise_k) pre++;
      g = tog_k[i] - prev;
      if (g < 1 || g > 3) bad++;
      sig = sig * 4 + g;
      prev = tog_k[i];
    end
    chk({tag, "_pre_toggles"}, pre, 5);
    chk({tag, "_rise_on_5th"}, rise_k, (tog_k.size() >= 5) ? tog_k[4] : -1);
    chk({tag, "_gap_range"}, bad, 0);
    chk({tag, "_fall_seen"}, {31'd0, fall_k > rise_k}, 1);
    chk({tag, "_d_at_fall"}, {31'd0, d_at_fall}, 1);
  endtask

  initial begin
    logic [15:0] lf, lf2, lf_unused;
    int          pre_end, sig1, sig2, sig4;
    st[0] = 1'b0;
    st[1] = 1'b0;
    st[2] = 1'b0;

    #2;
    chk("reset_dut", {20'd0, obs[0]}, 32'd0);
    chk("reset_fix", {20'd0, obs[1]}, 32'd0);
    chk("reset_one", {20'd0, obs[2]}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Cycle-exact schedule with fixed 3-cycle intervals
    @(negedge clk);
    st[1] = 1'b1;
    build_expect(5, 3, 3, 1, Seed, lf_unused, pre_end);
    run_compare(1, 0, 1000);

    // Single toggle per phase, 1-cycle interval
    @(negedge clk);
    st[2] = 1'b1;
    build_expect(1, 1, 1, 1, Seed, lf_unused, pre_end);
    run_compare(2, 0, 1000);

    // Random run 1 from seed, with a start pulse at e5 that must be ignored
    @(negedge clk);
    st[0] = 1'b1;
    build_expect(5, 1, 3, 1, Seed, lf, pre_end);
    run_compare(0, 5, 1000);
    check_props("run1", sig1);

    // Random run 2 without reset: LFSR continues, d_out restarts at 0, done clears
    @(negedge clk);
    st[0] = 1'b1;
    build_expect(5, 1, 3, 1, lf, lf2, pre_end);
    run_compare(0, 0, 1000);
    check_props("run2", sig2);
    chk("run2_gaps_differ", {31'd0, sig2 != sig1}, 1);

    // Random run 3, interrupted one cycle into RUN by an asynchronous reset
    @(negedge clk);
    st[0] = 1'b1;
    build_expect(5, 1, 3, 1, lf2, lf_unused, pre_end);
    run_compare(0, 0, pre_end + 1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", {20'd0, obs[0]}, 32'd0);
    chk("async_reset_cnt", {24'd0, tc0}, 32'd0);

    // Start held high across reset release: sampled on the first edge, LFSR back at seed
    st[0] = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    build_expect(5, 1, 3, 1, Seed, lf_unused, pre_end);
    run_compare(0, 0, 1000);
    check_props("run4", sig4);
    chk("post_reset_gaps_match_run1", sig4, sig1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
